// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle, MSB first).
// busy spans exactly DATA_W cycles after start; done pulses in the last busy cycle.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   adj_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Add-3 correction on every BCD digit >= 5 ahead of the shift.
    always_comb begin
        adj_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj_c[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                        : bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                // The first shift happens on the start edge itself.
                if (start) begin
                    state_d = ST_SHIFT;
                    sh_d    = value << 1;
                    bcd_d   = BCD_W'(value[DATA_W-1]);
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                sh_d  = sh_q << 1;
                bcd_d = {adj_c[BCD_W-2:0], sh_q[DATA_W-1]};
                ovf_d = ovf_q | adj_c[BCD_W-1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with hex and decimal (BCD) display modes.
// Define SEG7_BLINK_DP_EN to add per-digit blink_mask and dp_mask inputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [DATA_W-1:0]   value,
    input  logic                load,
    input  logic                dec_mode,
    input  logic                lz_blank,
`ifdef SEG7_BLINK_DP_EN
    input  logic [DIGITS-1:0]   blink_mask,
    input  logic [DIGITS-1:0]   dp_mask,
`endif
    output logic                busy,
    output logic                ovf,
    output logic [7:0]          SEG,
    output logic [DIGITS-1:0]   AN
);

    localparam int unsigned DISP_W = 4 * DIGITS;
    localparam int unsigned IDX_W  = clog2(DIGITS);
    localparam int unsigned CNT_W  = clog2(REFRESH_DIV);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  an_q, an_d;

    mode_e              mode_c;
    logic               term_c;
    logic               wrap_c;
    logic               hex_load_c;
    logic               dec_start_c;
    logic               conv_done;
    logic [DISP_W-1:0]  conv_bcd;
    logic               conv_ovf;
    logic [DIGITS-1:0]  lz_c;
    logic [3:0]         nib_c;

    assign mode_c      = dec_mode ? MODE_DEC : MODE_HEX;
    assign hex_load_c  = load && !busy && (mode_c == MODE_HEX);
    assign dec_start_c = load && !busy && (mode_c == MODE_DEC);
    assign term_c      = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign wrap_c      = (idx_q == IDX_W'(DIGITS - 1));

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .rst    (RST),
        .start  (dec_start_c),
        .value  (value),
        .busy   (busy),
        .done   (conv_done),
        .bcd    (conv_bcd),
        .ovf    (conv_ovf)
    );

    // Refresh counter and digit index.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (term_c) begin
            cnt_d = '0;
            idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Display register: hex loads write directly, conversions land on done.
    always_comb begin
        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (hex_load_c) begin
            disp_d = value[DISP_W-1:0];
            ovf_d  = 1'b0;
        end else if (conv_done) begin
            disp_d = conv_bcd;
            ovf_d  = conv_ovf;
        end
    end

`ifdef SEG7_BLINK_DP_EN
    logic [7:0] round_q, round_d;
    logic       phase_q, phase_d;

    // Blink phase flips after every 256 complete scan rounds.
    always_comb begin
        round_d = round_q;
        phase_d = phase_q;
        if (term_c && wrap_c) begin
            round_d = round_q + 8'd1;
            if (round_q == 8'hFF) begin
                phase_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            round_q <= '0;
            phase_q <= 1'b0;
        end else begin
            round_q <= round_d;
            phase_q <= phase_d;
        end
    end
`endif

    // lz_c[i]: digits i..DIGITS-1 are all zero.
    always_comb begin
        lz_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            lz_c[i] = ~|(disp_q >> (4 * i));
        end
    end

    always_comb begin
        nib_c = 4'(disp_q >> {idx_q, 2'b00});
        seg_d = SEG_TABLE[nib_c];
        if (lz_blank && (idx_q != '0) && lz_c[idx_q]) begin
            seg_d = SEG_BLANK;
        end
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end
`ifdef SEG7_BLINK_DP_EN
        if (dp_mask[idx_q]) begin
            seg_d[7] = 1'b0;
        end
        if (blink_mask[idx_q] && phase_q) begin
            seg_d = SEG_BLANK;
        end
`endif
        an_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
            seg_q  <= SEG_BLANK;
            an_q   <= '1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign ovf = ovf_q;
    assign SEG = seg_q;
    assign AN  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=8, DATA_W=32, REFRESH_DIV=4).
// Expected digits come from plain division/modulo of the loaded value.
module tb_seg7_scan_driver;

    localparam int DIGITS = 8;
    localparam int DIV    = 4;

    logic        clk = 1'b0;
    logic        RST;
    logic [31:0] value = '0;
    logic        load = 1'b0;
    logic        dec_mode = 1'b0;
    logic        lz_blank = 1'b0;
    logic        busy;
    logic        ovf;
    logic [7:0]  SEG;
    logic [7:0]  AN;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_dig [DIGITS];
    bit m_ovf = 1'b0;

    seg7_scan_driver #(
        .DIGITS      (8),
        .DATA_W      (32),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .value      (value),
        .load       (load),
        .dec_mode   (dec_mode),
        .lz_blank   (lz_blank),
`ifdef SEG7_BLINK_DP_EN
        .blink_mask (8'h00),
        .dp_mask    (8'h00),
`endif
        .busy       (busy),
        .ovf        (ovf),
        .SEG        (SEG),
        .AN         (AN)
    );

    always #5 clk = ~clk;

    // Edges since reset release; edge n shows digit ((n-1)/DIV) % DIGITS.
    always @(posedge clk or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
           12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int idx);
        bit allz;
        if (m_ovf) return 8'hBF;
        if (lz_blank && idx > 0) begin
            allz = 1'b1;
            for (int j = idx; j < DIGITS; j++) if (m_dig[j] != 0) allz = 1'b0;
            if (allz) return 8'hFF;
        end
        return seg_of(m_dig[idx]);
    endfunction

    function automatic logic [7:0] exp_an(input int idx);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << idx);
    endfunction

    task automatic model_hex(input logic [31:0] v);
        for (int i = 0; i < DIGITS; i++) m_dig[i] = int'((v >> (4 * i)) & 32'hF);
        m_ovf = 1'b0;
    endtask

    task automatic model_dec(input logic [31:0] v);
        longint t;
        if (v > 32'd99999999) begin
            m_ovf = 1'b1;
        end else begin
            m_ovf = 1'b0;
            t = longint'(v);
            for (int i = 0; i < DIGITS; i++) begin
                m_dig[i] = int'(t % 10);
                t = t / 10;
            end
        end
    endtask

    task automatic pulse_load(input logic [31:0] v, input logic dec);
        value    = v;
        dec_mode = dec;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #1 RST = 1'b1;
        #2;
        total++; if (SEG !== 8'hFF) begin bad++; $display("FAIL rst_seg: got %h want ff", SEG); end
        total++; if (AN !== 8'hFF) begin bad++; $display("FAIL rst_an: got %h want ff", AN); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        @(negedge clk);
        RST = 1'b0;
        lz_blank = 1'b1;
        model_hex(32'd0);
        @(negedge clk);
        total++; if (AN !== 8'hFE) begin bad++; $display("FAIL first_an: got %h want fe", AN); end
        for (int k = 0; k < 36; k++) begin
            int ix;
            ix = ((cyc - 1) / DIV) % DIGITS;
            total++; if (AN !== exp_an(ix)) begin bad++; $display("FAIL scan_an: cyc %0d got %h want %h", cyc, AN, exp_an(ix)); end
            total++; if (SEG !== exp_seg(ix)) begin bad++; $display("FAIL scan_seg: cyc %0d got %h want %h", cyc, SEG, exp_seg(ix)); end
            @(negedge clk);
        end
    endtask

    task automatic test_hex(input logic [31:0] v, input logic lz);
        lz_blank = lz;
        pulse_load(v, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hex_busy: got %b want 0", busy); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL hex_ovf: got %b want 0", ovf); end
        model_hex(v);
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            int ix;
            ix = ((cyc - 1) / DIV) % DIGITS;
            total++; if (AN !== exp_an(ix)) begin bad++; $display("FAIL hex_an: v %h got %h want %h", v, AN, exp_an(ix)); end
            total++; if (SEG !== exp_seg(ix)) begin bad++; $display("FAIL hex_seg: v %h digit %0d got %h want %h", v, ix, SEG, exp_seg(ix)); end
            @(negedge clk);
        end
    endtask

    task automatic test_decimal(input logic [31:0] v, input logic lz);
        int n;
        lz_blank = lz;
        pulse_load(v, 1'b1);
        n = 0;
        // Old content must stay on the display while converting.
        while (busy === 1'b1 && n < 100) begin
            int ix;
            n++;
            ix = ((cyc - 1) / DIV) % DIGITS;
            total++; if (SEG !== exp_seg(ix)) begin bad++; $display("FAIL dec_hold: n %0d got %h want %h", n, SEG, exp_seg(ix)); end
            @(negedge clk);
        end
        total++; if (n != 32) begin bad++; $display("FAIL dec_busy_len: got %0d want 32", n); end
        model_dec(v);
        total++; if (ovf !== m_ovf) begin bad++; $display("FAIL dec_ovf: v %0d got %b want %b", v, ovf, m_ovf); end
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            int ix;
            ix = ((cyc - 1) / DIV) % DIGITS;
            total++; if (AN !== exp_an(ix)) begin bad++; $display("FAIL dec_an: got %h want %h", AN, exp_an(ix)); end
            total++; if (SEG !== exp_seg(ix)) begin bad++; $display("FAIL dec_seg: v %0d digit %0d got %h want %h", v, ix, SEG, exp_seg(ix)); end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        test_decimal(32'd100000000, 1'b1);
        test_hex(32'd0, 1'b0);
    endtask

    task automatic test_ignore_load();
        int n;
        lz_blank = 1'b1;
        pulse_load(32'd42, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 10) begin
                value    = 32'h0000_0777;
                dec_mode = 1'b0;
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        total++; if (n != 32) begin bad++; $display("FAIL ign_busy_len: got %0d want 32", n); end
        model_dec(32'd42);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ign_ovf: got %b want 0", ovf); end
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            int ix;
            ix = ((cyc - 1) / DIV) % DIGITS;
            total++; if (SEG !== exp_seg(ix)) begin bad++; $display("FAIL ign_seg: digit %0d got %h want %h", ix, SEG, exp_seg(ix)); end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid();
        pulse_load(32'd987654, 1'b1);
        repeat (14) @(negedge clk);
        #2 RST = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (SEG !== 8'hFF) begin bad++; $display("FAIL mid_seg: got %h want ff", SEG); end
        total++; if (AN !== 8'hFF) begin bad++; $display("FAIL mid_an: got %h want ff", AN); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b want 0", ovf); end
        @(negedge clk);
        RST = 1'b0;
        lz_blank = 1'($urandom_range(0, 1));
        model_hex(32'd0);
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            int ix;
            ix = ((cyc - 1) / DIV) % DIGITS;
            total++; if (AN !== exp_an(ix)) begin bad++; $display("FAIL mid_scan_an: got %h want %h", AN, exp_an(ix)); end
            total++; if (SEG !== exp_seg(ix)) begin bad++; $display("FAIL mid_scan_seg: digit %0d got %h want %h", ix, SEG, exp_seg(ix)); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_scan_busy: got %b want 0", busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int unsigned sel;
            logic lz;
            sel = $urandom_range(0, 2);
            lz  = 1'($urandom_range(0, 1));
            case (sel)
                0:       test_hex($urandom, lz);
                1:       test_decimal($urandom_range(0, 99999999), lz);
                default: test_decimal($urandom, lz);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_hex(32'h1234ABCD, 1'b0);
        test_decimal(32'd12345678, 1'b0);
        test_overflow();
        test_ignore_load();
        test_rst_mid();
        test_decimal(32'd0, 1'b1);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
